// File: rtl/cpc_iowr_cfg_capture.sv
// -----------------------------------------------------------------------------
// cpc_iowr_cfg_capture
//
// Upstream stage of the 512K RAM expansion mapper. It samples the Z80 bus on
// wclk and looks for I/O writes to 0x7Fxx whose data[7:6] = 11. A write must
// stay qualified for FILTER_CYCLES consecutive samples before it is accepted,
// which filters out bus glitches. The bank/scheme byte is captured once per
// I/O cycle and presented as a registered 6-bit config {ccc,bbb}.
//
// Optional feature macro: CFG_READBACK_EN
//   When defined, an I/O read from 0x7Fxx returns {cfg_valid,1'b1,cfg} on
//   data_out with data_oe. When undefined, data_out/data_oe are tied to 0 and
//   rd_b is ignored.
//
// Parameters
//   FILTER_CYCLES : consecutive qualified samples needed before capture (1..7)
//   RESET_CFG     : cfg value after reset_b or busreset_b
//   CNT_W         : width of the capture counter wr_cnt
//
// Ports
//   wclk        in   CPU-rate clock, rising edge
//   reset_b     in   asynchronous active-low reset
//   busreset_b  in   expansion-bus reset, active-low, synchronous once sampled
//   adr15       in   Z80 A15
//   iorq_b      in   Z80 IORQ_n
//   wr_b        in   Z80 WR_n
//   rd_b        in   Z80 RD_n (readback only)
//   m1_b        in   Z80 M1_n (low together with IORQ_n = interrupt ack)
//   data_in     in   Z80 data bus [7:0]
//   cfg         out  captured config {ccc,bbb}
//   cfg_wr      out  one-cycle pulse when cfg updates from a bus write
//   cfg_valid   out  set by the first capture, cleared by either reset
//   wr_cnt      out  number of captures, wraps
//   data_out    out  readback data
//   data_oe     out  readback output enable
// -----------------------------------------------------------------------------
module cpc_iowr_cfg_capture #(
  parameter int unsigned FILTER_CYCLES = 2,
  parameter logic [5:0]  RESET_CFG     = 6'b000000,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             wclk,
  input  logic             reset_b,
  input  logic             busreset_b,
  input  logic             adr15,
  input  logic             iorq_b,
  input  logic             wr_b,
  input  logic             rd_b,
  input  logic             m1_b,
  input  logic [7:0]       data_in,
  output logic [5:0]       cfg,
  output logic             cfg_wr,
  output logic             cfg_valid,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [7:0]       data_out,
  output logic             data_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [2:0] FILT = 3'(FILTER_CYCLES);

  // ---------------------------------------------------------------------------
  // Stage 1: bus sampling. Everything downstream decodes only these registers,
  // so the asynchronous Z80 signals are seen through exactly one flop.
  // ---------------------------------------------------------------------------
  logic       iorq_s;
  logic       wr_s;
  logic       rd_s;
  logic       m1_s;
  logic       busreset_s;
  logic       adr15_s;
  logic [7:0] data_s;

  // NOTE: sequential state is always assigned with <= so that every flop sees
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge wclk or negedge reset_b) begin
    if (!reset_b) begin
      iorq_s     <= 1'b1;
      wr_s       <= 1'b1;
      rd_s       <= 1'b1;
      m1_s       <= 1'b1;
      busreset_s <= 1'b1;
      adr15_s    <= 1'b1;
      data_s     <= 8'h00;
    end else begin
      iorq_s     <= iorq_b;
      wr_s       <= wr_b;
      rd_s       <= rd_b;
      m1_s       <= m1_b;
      busreset_s <= busreset_b;
      adr15_s    <= adr15;
      data_s     <= data_in;
    end
  end

  // Qualified config write: I/O write (not interrupt ack) to A15=0 with the
  // gate-array function bits data[7:6] = 11.
  logic q_wr;
  assign q_wr = !iorq_s && !wr_s && m1_s && !adr15_s && (data_s[7:6] == 2'b11);

  // ---------------------------------------------------------------------------
  // Filter FSM: state register
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     next_state;
  logic [2:0] count;
  logic [2:0] next_count;
  logic [2:0] count_inc;

  assign count_inc = count + 3'd1;

  always_ff @(posedge wclk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
      count <= 3'd0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  // ---------------------------------------------------------------------------
  // Filter FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    next_count = count;
    if (!busreset_s) begin
      next_state = IDLE;
      next_count = 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (q_wr) begin
            if (FILT == 3'd1) begin
              next_state = HOLD;
              next_count = 3'd0;
            end else begin
              next_state = QUAL;
              next_count = 3'd1;
            end
          end
        end
        QUAL: begin
          if (!q_wr) begin
            next_state = IDLE;
            next_count = 3'd0;
          end else if (count_inc == FILT) begin
            next_state = HOLD;
            next_count = 3'd0;
          end else begin
            next_count = count_inc;
          end
        end
        HOLD: begin
          // One capture per I/O cycle: wait for IORQ to go inactive.
          if (iorq_s) begin
            next_state = IDLE;
          end
        end
        default: begin
          next_state = IDLE;
          next_count = 3'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Filter FSM: output decode. busreset has priority over a capture that
  // would complete on the same edge.
  // ---------------------------------------------------------------------------
  logic capture;

  always_comb begin
    capture = 1'b0;
    if (busreset_s && q_wr) begin
      if (state == IDLE && FILT == 3'd1) begin
        capture = 1'b1;
      end else if (state == QUAL && count_inc == FILT) begin
        capture = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Config register, strobe, valid flag and capture counter. wr_cnt survives
  // busreset so software can see how many writes happened across bus resets.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wclk or negedge reset_b) begin
    if (!reset_b) begin
      cfg       <= RESET_CFG;
      cfg_wr    <= 1'b0;
      cfg_valid <= 1'b0;
      wr_cnt    <= '0;
    end else begin
      cfg_wr <= capture;
      if (!busreset_s) begin
        cfg       <= RESET_CFG;
        cfg_valid <= 1'b0;
      end else if (capture) begin
        cfg       <= data_s[5:0];
        cfg_valid <= 1'b1;
        wr_cnt    <= wr_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional readback path
  // ---------------------------------------------------------------------------
`ifdef CFG_READBACK_EN
  logic q_rd;
  assign q_rd = !iorq_s && !rd_s && m1_s && !adr15_s;

  // cfg is read from its register here, so a capture on the same edge is not
  // yet visible and the pre-capture value is returned.
  always_ff @(posedge wclk or negedge reset_b) begin
    if (!reset_b) begin
      data_out <= 8'h00;
      data_oe  <= 1'b0;
    end else if (q_rd) begin
      data_out <= {cfg_valid, 1'b1, cfg};
      data_oe  <= 1'b1;
    end else begin
      data_oe  <= 1'b0;
    end
  end
`else
  logic unused_rd_s;
  assign unused_rd_s = rd_s;
  assign data_out    = 8'h00;
  assign data_oe     = 1'b0;
`endif

endmodule

// File: doc/cpc_iowr_cfg_capture.md
Name: cpc_iowr_cfg_capture

Overview:
Upstream stage of the 512K RAM expansion mapper. Samples Z80 bus signals on wclk, qualifies I/O write cycles to 0x7Fxx carrying data[7:6]=11, and filters glitches. Captures the bank/scheme byte once per I/O cycle and presents it as a registered 6-bit config (ccc_bbb) with a one-cycle update strobe. The downstream bank-mapping logic consumes cfg directly.

Parameters:
FILTER_CYCLES, 2, consecutive sampled cycles a qualified write must persist before capture (1..7)
RESET_CFG, 6'b000000, cfg value after reset_b or busreset_b (000 = all internal RAM)
CNT_W, 8, width of capture counter wr_cnt

Ports:
wclk  in  1  CPU-rate clock; all state updates on rising edge
reset_b  in  1  async active-low reset
busreset_b  in  1  expansion-bus reset, active-low, treated as synchronous after sampling
adr15  in  1  Z80 A15
iorq_b  in  1  Z80 IORQ, active-low
wr_b  in  1  Z80 WR, active-low
rd_b  in  1  Z80 RD, active-low
m1_b  in  1  Z80 M1, active-low; low with iorq_b = interrupt ack, never a write
data_in  in  8  Z80 data bus
cfg  out  6  captured config {ccc,bbb}
cfg_wr  out  1  one-cycle pulse on the cycle cfg updates from a bus write
cfg_valid  out  1  set by first capture, cleared by either reset
wr_cnt  out  CNT_W  number of captures, wraps
data_out  out  8  readback data (optional feature)
data_oe  out  1  readback output enable (optional feature)

Behaviour:
- Reset (reset_b low, async): cfg=RESET_CFG, cfg_wr=0, cfg_valid=0, wr_cnt=0, data_out=0, data_oe=0, FSM=IDLE, filter count=0. Sample regs preset to inactive: iorq/wr/rd/m1/busreset=1, adr15=1, data=0.
- Stage 1: every input registered once per edge (the _s signals). All decode uses only the _s signals.
- q_wr = !iorq_s & !wr_s & m1_s & !adr15_s & data_s[7:6]==2'b11.
- FSM states IDLE, QUAL, HOLD:
  - IDLE: if q_wr, go to QUAL with count=1. If FILTER_CYCLES=1, capture immediately and go to HOLD.
  - QUAL: if q_wr, count+1. On reaching FILTER_CYCLES, capture and go to HOLD. If !q_wr, abort to IDLE with no capture and count=0.
  - HOLD: stay while iorq_s=0. When iorq_s=1, go to IDLE. Exactly one capture per I/O cycle regardless of its length.
- Capture: cfg<=data_s[5:0] from the final qualifying sample, cfg_wr=1 for exactly one cycle, cfg_valid<=1, wr_cnt+1 (wraps all-ones to 0).
- Latency: if the bus condition is first present at edge k, cfg and cfg_wr update at edge k+FILTER_CYCLES.
- data_s[7:6] or adr15_s changing mid-QUAL drops q_wr and aborts; no partial capture.
- busreset_s=0: cfg=RESET_CFG, cfg_valid=0, FSM=IDLE, count=0, cfg_wr=0. wr_cnt is NOT cleared. busreset wins over a same-cycle capture.
- A write with data[7:6]!=11, to adr15=1, or during interrupt ack (m1_b=0) leaves cfg unchanged.
- cfg holds its value between captures. cfg_wr=0 whenever no capture occurs.

Optional Feature:
CFG_READBACK_EN
- Defined:
  - Qualified read q_rd = !iorq_s & !rd_s & m1_s & !adr15_s.
  - On q_rd, the next edge registers data_out={cfg_valid,1'b1,cfg} and data_oe=1.
  - data_oe drops on the edge after iorq_s or rd_s returns high.
  - Readback never affects the write FSM.
  - A capture and a readback in the same cycle return the pre-capture cfg.
- Undefined: data_out=0 and data_oe=0 constant; rd_b is unused.

Test Plan:
1. Reset, then IO write adr15=0, data=0xC2, held 4 cycles, FILTER_CYCLES=2 -> cfg=6'h02 at edge k+2, cfg_wr high for 1 cycle, cfg_valid=1, wr_cnt=1.
2. 1-cycle iorq_b/wr_b glitch with data=0xFF -> cfg unchanged, no cfg_wr, wr_cnt unchanged.
3. Write data=0xC9 with adr15=1, data=0x89 with adr15=0, and data=0xC9 with m1_b=0 -> no capture on any of the three.
4. Write 0xCA, then busreset_b low in the same cycle as the capture edge -> cfg=RESET_CFG, cfg_valid=0, cfg_wr=0. wr_cnt retains its prior value.
5. 256 valid writes alternating 0xC1/0xC3, each followed by iorq_b high -> wr_cnt wraps to 0 and the final cfg=6'h03. A single write held 10 cycles yields exactly one cfg_wr.
6. With CFG_READBACK_EN, cfg=6'h2A, cfg_valid=1: IO read adr15=0 -> data_out=0xEA, data_oe=1 from the next edge, cleared one edge after iorq_b rises. Without the macro -> data_oe stays 0.
